// File: rtl/btn_pkg.sv
// Shared definitions for board push-button conditioning.
// Provides the debouncer state encoding and the default stability window
// for the 100 MHz board clock.
package btn_pkg;

  // 10 ms of stable input at 100 MHz before a level change is accepted.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } btn_state_e;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset (both flops clear to 0)
//   d_i   - asynchronous input
//   q_o   - synchronised output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // First flop may go metastable; only the second flop is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/button_debouncer.sv
// Debounces one raw push-button pin into a clean level plus press/release
// strobes for the single-step and display logic.
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronised samples needed to
//                     accept a level change (must be >= 2)
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high reset
//   btn_raw      - asynchronous button pin
//   btn_db       - debounced level, registered
//   btn_pressed  - one-cycle pulse on accepted 0->1 transition, registered
//   btn_released - one-cycle pulse on accepted 1->0 transition, registered
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_pressed,
  output logic btn_released
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  btn_state_e       state_q,    state_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             db_q,       db_d;
  logic             pressed_q,  pressed_d;
  logic             released_q, released_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_raw),
    .q_o   (btn_sync)
  );

  // Next-state logic; any reversal while qualifying drops back without a pulse.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    db_d       = db_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_sync) begin
          state_d = S_PRESS_CHK;
          count_d = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!btn_sync) begin
          state_d = S_IDLE;
        end else if (count_q == CNT_LAST) begin
          state_d   = S_HELD;
          db_d      = 1'b1;
          pressed_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!btn_sync) begin
          state_d = S_REL_CHK;
          count_d = '0;
        end
      end
      S_REL_CHK: begin
        if (btn_sync) begin
          state_d = S_HELD;
        end else if (count_q == CNT_LAST) begin
          state_d    = S_IDLE;
          db_d       = 1'b0;
          released_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        db_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset never emits a release strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      db_q       <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      db_q       <= db_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign btn_db       = db_q;
  assign btn_pressed  = pressed_q;
  assign btn_released = released_q;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4.
// Reference model: the FSM input is the pin delayed through two flops; the
// debounced level flips once the last DEBOUNCE_CYCLES+1 samples all disagree
// with it.
module tb_button_debouncer;

  localparam int unsigned D = 4;
  localparam int LAT = D + 3;  // negedge samples from driving the pin to the output change

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_db;
  logic btn_pressed;
  logic btn_released;

  int n_checks = 0;
  int n_fail = 0;
  int n_press = 0;
  int n_rel = 0;
  int ev[$];
  bit chk_en = 1'b0;

  // Reference model state
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  bit m_db = 1'b0;
  bit m_pr = 1'b0;
  bit m_rl = 1'b0;
  int m_np = 0;
  int m_nr = 0;
  bit hist[$];

  button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_db       (btn_db),
    .btn_pressed  (btn_pressed),
    .btn_released (btn_released)
  );

  always #5 clk = ~clk;

  // Window-based reference model.
  always @(posedge clk) begin
    bit fsm_in;
    bit all_diff;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_pr = 1'b0; m_rl = 1'b0;
      hist.delete();
    end else begin
      fsm_in = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_pr = 1'b0;
      m_rl = 1'b0;
      hist.push_back(fsm_in);
      if (hist.size() > D + 1) void'(hist.pop_front());
      all_diff = (hist.size() == D + 1);
      foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = ~m_db;
        if (m_db) begin m_pr = 1'b1; m_np++; end
        else      begin m_rl = 1'b1; m_nr++; end
        hist.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (btn_db !== m_db) begin
        n_fail++;
        $display("FAIL model_btn_db t=%0t actual=%b expected=%b", $time, btn_db, m_db);
      end
      n_checks++;
      if (btn_pressed !== m_pr) begin
        n_fail++;
        $display("FAIL model_btn_pressed t=%0t actual=%b expected=%b", $time, btn_pressed, m_pr);
      end
      n_checks++;
      if (btn_released !== m_rl) begin
        n_fail++;
        $display("FAIL model_btn_released t=%0t actual=%b expected=%b", $time, btn_released, m_rl);
      end
      n_checks++;
      if ((btn_pressed & btn_released) !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_overlap t=%0t actual=%b expected=0", $time, btn_pressed & btn_released);
      end
      if (btn_pressed === 1'b1) begin n_press++; ev.push_back(1); end
      if (btn_released === 1'b1) begin n_rel++; ev.push_back(2); end
    end
  end

  task automatic hold(input logic raw, input int n);
    repeat (n) begin
      btn_raw = raw;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      btn_raw = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_en = 1'b1;
      n_checks++;
      if ({btn_db, btn_pressed, btn_released} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs actual=%b expected=000", {btn_db, btn_pressed, btn_released});
      end
    end
    btn_raw = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    int lat;
    int p0;
    int r0;
    hold(1'b0, 12);
    #1;
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b1;
    lat = 0;
    while (btn_db !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL press_latency actual=%0d expected=%0d", lat, LAT);
    end
    n_checks++;
    if (btn_pressed !== 1'b1) begin
      n_fail++;
      $display("FAIL press_pulse_at_rise actual=%b expected=1", btn_pressed);
    end
    hold(1'b1, 20 - lat);
    #1;
    n_checks++;
    if (n_press - p0 != 1 || n_rel - r0 != 0) begin
      n_fail++;
      $display("FAIL press_pulse_count actual=%0d/%0d expected=1/0", n_press - p0, n_rel - r0);
    end
  endtask

  task automatic test_bounce_press();
    int lat;
    int p0;
    hold(1'b0, 12);
    #1;
    p0 = n_press;
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
    #1;
    n_checks++;
    if (n_press != p0 || btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_no_pulse actual=%0d,%b expected=0,0", n_press - p0, btn_db);
    end
    btn_raw = 1'b1;
    lat = 0;
    while (btn_db !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL bounce_press_latency actual=%0d expected=%0d", lat, LAT);
    end
    hold(1'b1, 20);
    #1;
    n_checks++;
    if (n_press - p0 != 1) begin
      n_fail++;
      $display("FAIL bounce_press_count actual=%0d expected=1", n_press - p0);
    end
  endtask

  task automatic test_clean_release();
    int lat;
    int p0;
    int r0;
    #1;
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b0;
    lat = 0;
    while (btn_db !== 1'b0 && lat < 30) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL release_latency actual=%0d expected=%0d", lat, LAT);
    end
    n_checks++;
    if (btn_released !== 1'b1 || btn_pressed !== 1'b0) begin
      n_fail++;
      $display("FAIL release_pulse_at_fall actual=%b%b expected=10", btn_released, btn_pressed);
    end
    hold(1'b0, 20 - lat);
    #1;
    n_checks++;
    if (n_rel - r0 != 1 || n_press - p0 != 0) begin
      n_fail++;
      $display("FAIL release_pulse_count actual=%0d/%0d expected=1/0", n_rel - r0, n_press - p0);
    end
  endtask

  task automatic test_short_glitch();
    logic hi;
    hold(1'b0, 12);
    hi = 1'b0;
    for (int i = 0; i < 18; i++) begin
      btn_raw = (i < 3);
      @(negedge clk);
      hi = hi | btn_db | btn_pressed | btn_released;
    end
    n_checks++;
    if (hi !== 1'b0) begin
      n_fail++;
      $display("FAIL short_glitch_outputs actual=%b expected=0", hi);
    end
  endtask

  task automatic test_reset_held();
    int lat;
    int r0;
    hold(1'b1, 12);
    n_checks++;
    if (btn_db !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held_setup actual=%b expected=1", btn_db);
    end
    #1;
    r0 = n_rel;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (btn_db !== 1'b0 || btn_released !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_clear actual=%b%b expected=00", btn_db, btn_released);
    end
    reset = 1'b0;
    lat = 0;
    while (btn_pressed !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL reset_requalify_latency actual=%0d expected=%0d", lat, LAT);
    end
    hold(1'b1, 4);
    #1;
    n_checks++;
    if (n_rel != r0) begin
      n_fail++;
      $display("FAIL reset_no_release actual=%0d expected=0", n_rel - r0);
    end
  endtask

  task automatic test_back_to_back();
    hold(1'b0, 12);
    #1;
    ev.delete();
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 10);
    #1;
    n_checks++;
    if (ev.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_event_count actual=%0d expected=3", ev.size());
    end else begin
      n_checks++;
      if (ev[0] != 1 || ev[1] != 2 || ev[2] != 1) begin
        n_fail++;
        $display("FAIL b2b_event_order actual=%0d,%0d,%0d expected=1,2,1", ev[0], ev[1], ev[2]);
      end
    end
  endtask

  task automatic test_random();
    int p0;
    int r0;
    int mp0;
    int mr0;
    #1;
    p0 = n_press; r0 = n_rel; mp0 = m_np; mr0 = m_nr;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        btn_raw = 1'($urandom_range(0, 1));
        @(negedge clk);
        reset = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    end
    hold(1'b0, 12);
    #1;
    n_checks++;
    if (n_press - p0 != m_np - mp0 || n_rel - r0 != m_nr - mr0) begin
      n_fail++;
      $display("FAIL random_pulse_totals actual=%0d/%0d expected=%0d/%0d",
               n_press - p0, n_rel - r0, m_np - mp0, m_nr - mr0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce_press();
    test_clean_release();
    test_short_glitch();
    test_reset_held();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions one raw push-button input (e.g. BTNC) for the processor's single-step and display logic.
- Synchronises the asynchronous pin, rejects bounce with a stability counter, and exposes three signals to the downstream write-tracker/display stage:
  - a debounced level
  - a one-cycle press pulse
  - a one-cycle release pulse
- One instance per board button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous button pin.
- btn_db  output  1  debounced button level, registered.
- btn_pressed  output  1  single-cycle pulse on accepted 0->1 transition.
- btn_released  output  1  single-cycle pulse on accepted 1->0 transition.

Behaviour:
- Clocking and reset:
  - One clock, `clk`; reset is synchronous and active-high, port `reset`.
  - All state changes on posedge clk only.
- Synchroniser:
  - Two flops, btn_raw -> s1 -> s2; both reset to 0.
  - Only s2 is used internally.
- Reset values:
  - btn_db=0, btn_pressed=0, btn_released=0, state=S_IDLE, count=0.
- FSM states (registered, 2-bit encoding):
  - S_IDLE: btn_db=0. If s2=1: go to S_PRESS_CHK, count<=0.
  - S_PRESS_CHK: btn_db=0.
    - If s2=0: go to S_IDLE. This is a glitch; no pulse.
    - Else if count==DEBOUNCE_CYCLES-1: go to S_HELD, btn_db<=1, btn_pressed<=1.
    - Else count<=count+1.
  - S_HELD: btn_db=1. If s2=0: go to S_REL_CHK, count<=0.
  - S_REL_CHK: btn_db=1.
    - If s2=1: go to S_HELD. This is a glitch; no pulse.
    - Else if count==DEBOUNCE_CYCLES-1: go to S_IDLE, btn_db<=0, btn_released<=1.
    - Else count<=count+1.
- Pulse outputs:
  - btn_pressed and btn_released are high for exactly one cycle, coincident with the first cycle of the new btn_db value.
  - Both deassert on every other cycle.
  - They are never high together.
- Latency:
  - Take edge E as the first edge at which s1 samples btn_raw=1, with btn_raw held stable thereafter.
  - btn_db, and the pulse, change after edge E+DEBOUNCE_CYCLES+2.
  - The release direction has the same latency.
- Glitch rejection:
  - Any s2 reversal during a CHK state resets qualification.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes btn_db.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Never wraps.
  - Holds its value in S_IDLE and S_HELD.
- Reset mid-operation:
  - Returns to S_IDLE with btn_db=0 regardless of state.
  - No btn_released pulse is generated by reset.
  - A button held through reset is re-qualified and then produces btn_pressed.
- Reset and button transition in the same cycle: reset wins.
- Downstream contract:
  - btn_db is used as the "hold/show" level.
  - btn_released is used as the commit strobe.
  - Both are glitch-free registered outputs.

Decomposition:
- Shared package (btn_pkg): state localparams S_IDLE=2'd0, S_PRESS_CHK=2'd1, S_HELD=2'd2, S_REL_CHK=2'd3; default DEBOUNCE_CYCLES constant for the 100 MHz board clock.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, synchronous active-high reset), reusable for other board inputs.
- FSM, counter and output registers stay in button_debouncer.

Test Plan (DEBOUNCE_CYCLES=4 for all benches):
- Clean press: btn_raw 0->1 held 20 cycles -> btn_db rises exactly 6 edges after first s1 capture; btn_pressed high one cycle at that point; btn_released stays 0.
- Bounce on press: btn_raw toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during bounce; exactly one btn_pressed, timed 6 edges after the final stable rise is captured.
- Clean release: from held, btn_raw 1->0 held 20 cycles -> btn_db falls after 6 edges; btn_released high exactly one cycle; btn_pressed 0.
- Short glitch: btn_raw high for 3 cycles from idle -> btn_db, btn_pressed and btn_released all remain 0 throughout.
- Reset while held: btn_db=1, assert reset 1 cycle with btn_raw still 1 -> next cycle btn_db=0 with no btn_released; then btn_pressed fires once after re-qualification (~6 cycles).
- Back-to-back: press 10 cycles, release 10 cycles, press 10 cycles -> exactly pressed, released, pressed pulses in order, each one cycle wide, never overlapping.
